// File: rtl/axi_channel_buffer_if.sv
// axi_channel_buffer_if
//   AXI4 bus bundle (AW, W, B, AR, R channels, including region/qos/user) used by
//   axi_channel_buffer on both its upstream and downstream sides.
//   Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH.
//   Modports:
//     master - drives aw/w/ar payload+valid and b/r ready; receives the rest
//     slave  - mirror image of master
interface axi_channel_buffer_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [3:0]                aw_qos;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_last;
  logic                      w_valid;
  logic                      w_ready;

  logic [1:0]                b_resp;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [3:0]                ar_qos;
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_addr, aw_prot, aw_region, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_qos,
           aw_id, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_user, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_id, b_user, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_qos,
           ar_id, ar_user, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_id, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_addr, aw_prot, aw_region, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_qos,
           aw_id, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_user, w_last, w_valid,
    output w_ready,
    output b_resp, b_id, b_user, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_qos,
           ar_id, ar_user, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_id, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_channel_buffer.sv
// axi_channel_buffer
//   Per-channel AXI4 buffer: one FIFO of independent depth per channel (AW, W, B, AR, R).
//   Request channels flow slv -> mst, response channels flow mst -> slv. Depth 0 makes a
//   channel plain wires. All fields, including region/qos/user, pass through unchanged.
//   Ports:
//     clk_i   - clock, all state on rising edge
//     rst_ni  - asynchronous active-low reset (empties every FIFO)
//     slv     - upstream side (axi_channel_buffer_if.slave)
//     mst     - downstream side (axi_channel_buffer_if.master)
//     idle_o  - 1 when every FIFO is empty
//   Build option: define AXI_CHANNEL_BUFFER_FALLTHROUGH_EN to let a beat bypass an empty FIFO
//   combinationally when the downstream is ready (0-cycle latency, nothing stored).

module axi_channel_buffer_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              empty
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
    assign empty     = 1'b1;
  end else begin : g_fifo
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              stored_empty, wr_en, rd_en;

    assign stored_empty = (count == '0);
    // Ready comes only from registered occupancy so no ready path crosses the buffer.
    assign in_ready = (count != FULL_CNT);
    assign empty    = stored_empty;
    assign rd_en    = out_ready & !stored_empty;

`ifdef AXI_CHANNEL_BUFFER_FALLTHROUGH_EN
    logic bypass;
    // Empty and downstream ready: the beat goes straight through and is never written.
    assign bypass    = stored_empty & out_ready;
    assign out_valid = bypass ? in_valid : !stored_empty;
    assign out_data  = bypass ? in_data : mem[rd_ptr];
    assign wr_en     = in_valid & in_ready & !bypass;
`else
    assign out_valid = !stored_empty;
    assign out_data  = mem[rd_ptr];
    assign wr_en     = in_valid & in_ready;
`endif

    // Storage stage boundary: control state (pointers wrap at DEPTH-1, any depth allowed)
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        if (wr_en != rd_en) count <= wr_en ? count + 1'b1 : count - 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= in_data;
    end
  end
endmodule

module axi_channel_buffer #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AW_DEPTH       = 2,
  parameter int unsigned W_DEPTH        = 2,
  parameter int unsigned B_DEPTH        = 2,
  parameter int unsigned AR_DEPTH       = 2,
  parameter int unsigned R_DEPTH        = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  axi_channel_buffer_if.slave   slv,
  axi_channel_buffer_if.master  mst,
  output logic                  idle_o
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned AX_W   = AXI_ADDR_WIDTH + AXI_ID_WIDTH + AXI_USER_WIDTH + 29;
  localparam int unsigned W_W    = AXI_DATA_WIDTH + STRB_W + AXI_USER_WIDTH + 1;
  localparam int unsigned B_W    = 2 + AXI_ID_WIDTH + AXI_USER_WIDTH;
  localparam int unsigned R_W    = AXI_DATA_WIDTH + 3 + AXI_ID_WIDTH + AXI_USER_WIDTH;

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;
  logic            aw_empty, w_empty, b_empty, ar_empty, r_empty;

  assign aw_in = {slv.aw_addr, slv.aw_prot, slv.aw_region, slv.aw_len, slv.aw_size,
                  slv.aw_burst, slv.aw_lock, slv.aw_cache, slv.aw_qos, slv.aw_id, slv.aw_user};
  assign {mst.aw_addr, mst.aw_prot, mst.aw_region, mst.aw_len, mst.aw_size,
          mst.aw_burst, mst.aw_lock, mst.aw_cache, mst.aw_qos, mst.aw_id, mst.aw_user} = aw_out;

  assign w_in = {slv.w_data, slv.w_strb, slv.w_user, slv.w_last};
  assign {mst.w_data, mst.w_strb, mst.w_user, mst.w_last} = w_out;

  assign b_in = {mst.b_resp, mst.b_id, mst.b_user};
  assign {slv.b_resp, slv.b_id, slv.b_user} = b_out;

  assign ar_in = {slv.ar_addr, slv.ar_prot, slv.ar_region, slv.ar_len, slv.ar_size,
                  slv.ar_burst, slv.ar_lock, slv.ar_cache, slv.ar_qos, slv.ar_id, slv.ar_user};
  assign {mst.ar_addr, mst.ar_prot, mst.ar_region, mst.ar_len, mst.ar_size,
          mst.ar_burst, mst.ar_lock, mst.ar_cache, mst.ar_qos, mst.ar_id, mst.ar_user} = ar_out;

  assign r_in = {mst.r_data, mst.r_resp, mst.r_last, mst.r_id, mst.r_user};
  assign {slv.r_data, slv.r_resp, slv.r_last, slv.r_id, slv.r_user} = r_out;

  axi_channel_buffer_fifo #(.DEPTH(AW_DEPTH), .DATA_W(AX_W)) i_aw_fifo (
    .clk_i, .rst_ni,
    .in_valid(slv.aw_valid), .in_ready(slv.aw_ready), .in_data(aw_in),
    .out_valid(mst.aw_valid), .out_ready(mst.aw_ready), .out_data(aw_out), .empty(aw_empty)
  );

  axi_channel_buffer_fifo #(.DEPTH(W_DEPTH), .DATA_W(W_W)) i_w_fifo (
    .clk_i, .rst_ni,
    .in_valid(slv.w_valid), .in_ready(slv.w_ready), .in_data(w_in),
    .out_valid(mst.w_valid), .out_ready(mst.w_ready), .out_data(w_out), .empty(w_empty)
  );

  axi_channel_buffer_fifo #(.DEPTH(B_DEPTH), .DATA_W(B_W)) i_b_fifo (
    .clk_i, .rst_ni,
    .in_valid(mst.b_valid), .in_ready(mst.b_ready), .in_data(b_in),
    .out_valid(slv.b_valid), .out_ready(slv.b_ready), .out_data(b_out), .empty(b_empty)
  );

  axi_channel_buffer_fifo #(.DEPTH(AR_DEPTH), .DATA_W(AX_W)) i_ar_fifo (
    .clk_i, .rst_ni,
    .in_valid(slv.ar_valid), .in_ready(slv.ar_ready), .in_data(ar_in),
    .out_valid(mst.ar_valid), .out_ready(mst.ar_ready), .out_data(ar_out), .empty(ar_empty)
  );

  axi_channel_buffer_fifo #(.DEPTH(R_DEPTH), .DATA_W(R_W)) i_r_fifo (
    .clk_i, .rst_ni,
    .in_valid(mst.r_valid), .in_ready(mst.r_ready), .in_data(r_in),
    .out_valid(slv.r_valid), .out_ready(slv.r_ready), .out_data(r_out), .empty(r_empty)
  );

  // Zero-depth channels report empty, so they never hold idle_o low.
  assign idle_o = aw_empty & w_empty & b_empty & ar_empty & r_empty;
endmodule

// File: tb/tb_axi_channel_buffer.sv
`timescale 1ns/1ps
module tb_axi_channel_buffer;
  localparam int AWID = 32, DW = 64, IW = 10, UW = 6, SW = DW / 8;
  localparam int AW_D = 2, W_D = 3, B_D = 0, AR_D = 2, R_D = 2;
`ifdef AXI_CHANNEL_BUFFER_FALLTHROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  axi_channel_buffer_if #(.AXI_ADDR_WIDTH(AWID), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                          .AXI_USER_WIDTH(UW)) slv_bus ();
  axi_channel_buffer_if #(.AXI_ADDR_WIDTH(AWID), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                          .AXI_USER_WIDTH(UW)) mst_bus ();

  axi_channel_buffer #(
    .AXI_ADDR_WIDTH(AWID), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW),
    .AW_DEPTH(AW_D), .W_DEPTH(W_D), .B_DEPTH(B_D), .AR_DEPTH(AR_D), .R_DEPTH(R_D)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .slv(slv_bus), .mst(mst_bus), .idle_o(idle)
  );

  task automatic clear_inputs();
    slv_bus.aw_addr = '0; slv_bus.aw_prot = '0; slv_bus.aw_region = '0; slv_bus.aw_len = '0;
    slv_bus.aw_size = '0; slv_bus.aw_burst = '0; slv_bus.aw_lock = 1'b0; slv_bus.aw_cache = '0;
    slv_bus.aw_qos = '0; slv_bus.aw_id = '0; slv_bus.aw_user = '0; slv_bus.aw_valid = 1'b0;
    slv_bus.w_data = '0; slv_bus.w_strb = '0; slv_bus.w_user = '0; slv_bus.w_last = 1'b0;
    slv_bus.w_valid = 1'b0;
    slv_bus.ar_addr = '0; slv_bus.ar_prot = '0; slv_bus.ar_region = '0; slv_bus.ar_len = '0;
    slv_bus.ar_size = '0; slv_bus.ar_burst = '0; slv_bus.ar_lock = 1'b0; slv_bus.ar_cache = '0;
    slv_bus.ar_qos = '0; slv_bus.ar_id = '0; slv_bus.ar_user = '0; slv_bus.ar_valid = 1'b0;
    slv_bus.b_ready = 1'b0; slv_bus.r_ready = 1'b0;
    mst_bus.aw_ready = 1'b0; mst_bus.w_ready = 1'b0; mst_bus.ar_ready = 1'b0;
    mst_bus.b_resp = '0; mst_bus.b_id = '0; mst_bus.b_user = '0; mst_bus.b_valid = 1'b0;
    mst_bus.r_data = '0; mst_bus.r_resp = '0; mst_bus.r_last = 1'b0; mst_bus.r_id = '0;
    mst_bus.r_user = '0; mst_bus.r_valid = 1'b0;
  endtask

  // Reset held with random valids/payloads: every valid low, every ready high, idle high.
  task automatic test_reset();
    logic [10:0] got;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      slv_bus.aw_valid = 1'($urandom); slv_bus.aw_addr = $urandom;
      slv_bus.w_valid = 1'($urandom);  slv_bus.w_data = {$urandom, $urandom};
      slv_bus.ar_valid = 1'($urandom); slv_bus.ar_addr = $urandom;
      mst_bus.r_valid = 1'($urandom);  mst_bus.r_data = {$urandom, $urandom};
      mst_bus.b_valid = 1'b0;          slv_bus.b_ready = 1'b1;
      #1;
      got = {mst_bus.aw_valid, mst_bus.w_valid, mst_bus.ar_valid, slv_bus.r_valid, slv_bus.b_valid,
             slv_bus.aw_ready, slv_bus.w_ready, slv_bus.ar_ready, mst_bus.r_ready, mst_bus.b_ready,
             idle};
      checks++;
      if (got !== 11'b00000_11111_1) begin
        errors++;
        $display("FAIL reset_state: got %b want 00000111111 (valids,readys,idle)", got);
      end
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
  endtask

  // Reset asserted between edges must empty the buffer immediately, and the beat is lost.
  task automatic test_async_reset();
    @(negedge clk);
    slv_bus.aw_valid = 1'b1; slv_bus.aw_addr = 32'hDEAD_0000; mst_bus.aw_ready = 1'b0;
    @(negedge clk);
    slv_bus.aw_valid = 1'b0;
    #1;
    checks++;
    if (mst_bus.aw_valid !== 1'b1) begin
      errors++; $display("FAIL async_pre_valid: got %b want 1", mst_bus.aw_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mst_bus.aw_valid, slv_bus.aw_ready, idle} !== 3'b011) begin
      errors++;
      $display("FAIL async_reset: got valid/ready/idle=%b want 011",
               {mst_bus.aw_valid, slv_bus.aw_ready, idle});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (mst_bus.aw_valid !== 1'b0) begin
      errors++; $display("FAIL async_discard: got valid %b want 0", mst_bus.aw_valid);
    end
  endtask

  // AW depth 2: fill with downstream stalled, then drain.
  task automatic test_aw_fill();
    @(negedge clk);
    slv_bus.aw_valid = 1'b1; slv_bus.aw_addr = 32'h1000; slv_bus.aw_id = 10'd3;
    slv_bus.aw_len = 8'd7; slv_bus.aw_user = 6'h2A; slv_bus.aw_qos = 4'h9; mst_bus.aw_ready = 1'b0;
    #1;
    checks++;
    if ({slv_bus.aw_ready, mst_bus.aw_valid} !== 2'b10) begin
      errors++; $display("FAIL aw_first: got ready/valid=%b want 10",
                         {slv_bus.aw_ready, mst_bus.aw_valid});
    end
    @(negedge clk);
    slv_bus.aw_addr = 32'h2000; slv_bus.aw_id = 10'd4; slv_bus.aw_user = 6'h15; slv_bus.aw_qos = 4'h1;
    #1;
    checks++;
    if ({slv_bus.aw_ready, mst_bus.aw_valid, mst_bus.aw_addr} !== {2'b11, 32'h1000}) begin
      errors++; $display("FAIL aw_second: got ready/valid=%b addr=%h want 11 1000",
                         {slv_bus.aw_ready, mst_bus.aw_valid}, mst_bus.aw_addr);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      slv_bus.aw_valid = 1'b0;
      #1;
      checks++;
      if ({slv_bus.aw_ready, mst_bus.aw_valid, mst_bus.aw_addr, mst_bus.aw_id, mst_bus.aw_len,
           mst_bus.aw_user, mst_bus.aw_qos} !== {2'b01, 32'h1000, 10'd3, 8'd7, 6'h2A, 4'h9}) begin
        errors++; $display("FAIL aw_full_hold: got ready/valid=%b addr=%h id=%0d user=%h",
                           {slv_bus.aw_ready, mst_bus.aw_valid}, mst_bus.aw_addr, mst_bus.aw_id,
                           mst_bus.aw_user);
      end
    end
    @(negedge clk);
    mst_bus.aw_ready = 1'b1;
    #1;
    checks++;
    if ({slv_bus.aw_ready, mst_bus.aw_valid, mst_bus.aw_addr} !== {2'b01, 32'h1000}) begin
      errors++; $display("FAIL aw_drain0: got ready/valid=%b addr=%h want 01 1000",
                         {slv_bus.aw_ready, mst_bus.aw_valid}, mst_bus.aw_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({slv_bus.aw_ready, mst_bus.aw_valid, mst_bus.aw_addr, mst_bus.aw_id, mst_bus.aw_user}
        !== {2'b11, 32'h2000, 10'd4, 6'h15}) begin
      errors++; $display("FAIL aw_drain1: got ready/valid=%b addr=%h id=%0d want 11 2000 4",
                         {slv_bus.aw_ready, mst_bus.aw_valid}, mst_bus.aw_addr, mst_bus.aw_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mst_bus.aw_valid, idle} !== 2'b01) begin
      errors++; $display("FAIL aw_empty: got valid/idle=%b want 01", {mst_bus.aw_valid, idle});
    end
    mst_bus.aw_ready = 1'b0;
  endtask

  // W depth 3: three 8-beat bursts (data 0..7, last on beat 7) with random valid/ready.
  task automatic test_w_burst();
    localparam int NB = 24;
    localparam int BW = DW + SW + UW + 1;
    logic [BW-1:0] q[$];
    logic [BW-1:0] beat, exp;
    int  sent = 0, recv = 0, cyc = 0;
    bit  holding = 1'b0, exp_valid, can_push, bypass;
    beat = '0;
    while (recv < NB && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (!holding && sent < NB && $urandom_range(0, 3) != 0) begin
        beat = {DW'(sent % 8), SW'($urandom), UW'($urandom), 1'((sent % 8) == 7)};
        holding = 1'b1;
      end
      slv_bus.w_valid = holding;
      {slv_bus.w_data, slv_bus.w_strb, slv_bus.w_user, slv_bus.w_last} = beat;
      mst_bus.w_ready = 1'($urandom);
      #1;
      can_push = (q.size() < W_D);
      bypass = FT && (q.size() == 0) && mst_bus.w_ready;
      exp_valid = bypass ? holding : (q.size() != 0);
      exp = bypass ? beat : ((q.size() != 0) ? q[0] : '0);
      checks++;
      if (slv_bus.w_ready !== can_push) begin
        errors++; $display("FAIL w_in_ready: got %b want %b (cycle %0d)", slv_bus.w_ready, can_push, cyc);
      end
      checks++;
      if (mst_bus.w_valid !== exp_valid) begin
        errors++; $display("FAIL w_out_valid: got %b want %b (cycle %0d)", mst_bus.w_valid, exp_valid, cyc);
      end
      if (exp_valid && mst_bus.w_valid === 1'b1) begin
        checks++;
        if ({mst_bus.w_data, mst_bus.w_strb, mst_bus.w_user, mst_bus.w_last} !== exp) begin
          errors++; $display("FAIL w_payload: got data=%0d strb=%h user=%h last=%b want %h",
                             mst_bus.w_data, mst_bus.w_strb, mst_bus.w_user, mst_bus.w_last, exp);
        end
      end
      if (bypass) begin
        if (holding) begin sent++; recv++; holding = 1'b0; end
      end else begin
        if (exp_valid && mst_bus.w_ready) begin void'(q.pop_front()); recv++; end
        if (holding && can_push) begin q.push_back(beat); sent++; holding = 1'b0; end
      end
    end
    @(negedge clk);
    slv_bus.w_valid = 1'b0; mst_bus.w_ready = 1'b0;
    checks++;
    if (recv != NB) begin
      errors++; $display("FAIL w_burst_done: got %0d beats want %0d", recv, NB);
    end
  endtask

  // R depth 2: fill, offer a third beat while full and draining.
  task automatic test_r_full();
    @(negedge clk);
    mst_bus.r_valid = 1'b1; mst_bus.r_data = 64'hA; mst_bus.r_id = 10'd1; mst_bus.r_resp = 2'b00;
    slv_bus.r_ready = 1'b0;
    #1;
    checks++;
    if ({mst_bus.r_ready, slv_bus.r_valid} !== 2'b10) begin
      errors++; $display("FAIL r_fill0: got ready/valid=%b want 10", {mst_bus.r_ready, slv_bus.r_valid});
    end
    @(negedge clk);
    mst_bus.r_data = 64'hB; mst_bus.r_id = 10'd2; mst_bus.r_resp = 2'b00; mst_bus.r_last = 1'b1;
    #1;
    checks++;
    if ({mst_bus.r_ready, slv_bus.r_valid, slv_bus.r_data} !== {2'b11, 64'hA}) begin
      errors++; $display("FAIL r_fill1: got ready/valid=%b data=%h",
                         {mst_bus.r_ready, slv_bus.r_valid}, slv_bus.r_data);
    end
    @(negedge clk);
    mst_bus.r_data = 64'hC; mst_bus.r_id = 10'd3; mst_bus.r_resp = 2'b01; mst_bus.r_last = 1'b0;
    #1;
    checks++;
    if ({mst_bus.r_ready, idle} !== 2'b00) begin
      errors++; $display("FAIL r_full: got ready/idle=%b want 00", {mst_bus.r_ready, idle});
    end
    @(negedge clk);
    slv_bus.r_ready = 1'b1;
    #1;
    checks++;
    if ({mst_bus.r_ready, slv_bus.r_valid, slv_bus.r_data, slv_bus.r_id, slv_bus.r_resp}
        !== {2'b01, 64'hA, 10'd1, 2'b00}) begin
      errors++; $display("FAIL r_full_pop: got ready/valid=%b data=%h id=%0d resp=%b",
                         {mst_bus.r_ready, slv_bus.r_valid}, slv_bus.r_data, slv_bus.r_id, slv_bus.r_resp);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mst_bus.r_ready, slv_bus.r_valid, slv_bus.r_data, slv_bus.r_id, slv_bus.r_resp, slv_bus.r_last}
        !== {2'b11, 64'hB, 10'd2, 2'b00, 1'b1}) begin
      errors++; $display("FAIL r_push_pop: got ready/valid=%b data=%h id=%0d last=%b",
                         {mst_bus.r_ready, slv_bus.r_valid}, slv_bus.r_data, slv_bus.r_id, slv_bus.r_last);
    end
    @(negedge clk);
    mst_bus.r_valid = 1'b0;
    #1;
    checks++;
    if ({slv_bus.r_valid, slv_bus.r_data, slv_bus.r_id, slv_bus.r_resp} !== {1'b1, 64'hC, 10'd3, 2'b01}) begin
      errors++; $display("FAIL r_third: got valid=%b data=%h id=%0d resp=%b",
                         slv_bus.r_valid, slv_bus.r_data, slv_bus.r_id, slv_bus.r_resp);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({slv_bus.r_valid, idle} !== 2'b01) begin
      errors++; $display("FAIL r_drained: got valid/idle=%b want 01", {slv_bus.r_valid, idle});
    end
    slv_bus.r_ready = 1'b0;
  endtask

  // B depth 0: wires in both directions, visible before any clock edge.
  task automatic test_b_passthrough();
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic [UW-1:0] user;
    logic          v, rdy;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v    = (i == 0) ? 1'b1 : 1'($urandom);
      id   = (i == 0) ? 10'd5 : IW'($urandom);
      resp = 2'($urandom); user = UW'($urandom); rdy = 1'b0;
      mst_bus.b_valid = v; mst_bus.b_id = id; mst_bus.b_resp = resp; mst_bus.b_user = user;
      slv_bus.b_ready = rdy;
      #1;
      checks++;
      if ({slv_bus.b_valid, slv_bus.b_id, slv_bus.b_resp, slv_bus.b_user, mst_bus.b_ready, idle}
          !== {v, id, resp, user, rdy, 1'b1}) begin
        errors++; $display("FAIL b_pass: got valid=%b id=%0d ready=%b idle=%b want valid=%b id=%0d",
                           slv_bus.b_valid, slv_bus.b_id, mst_bus.b_ready, idle, v, id);
      end
      rdy = 1'b1;
      slv_bus.b_ready = rdy;
      #1;
      checks++;
      if (mst_bus.b_ready !== rdy) begin
        errors++; $display("FAIL b_ready_pass: got %b want %b", mst_bus.b_ready, rdy);
      end
    end
    @(negedge clk);
    mst_bus.b_valid = 1'b0; slv_bus.b_ready = 1'b0;
  endtask

  // AR single beat into an empty FIFO with downstream ready: latency and idle behaviour.
  task automatic test_ar_latency();
    @(negedge clk);
    mst_bus.ar_ready = 1'b1; slv_bus.ar_valid = 1'b1; slv_bus.ar_addr = 32'h40; slv_bus.ar_id = 10'd9;
    #1;
    checks++;
`ifdef AXI_CHANNEL_BUFFER_FALLTHROUGH_EN
    if ({mst_bus.ar_valid, mst_bus.ar_addr, idle} !== {1'b1, 32'h40, 1'b1}) begin
      errors++; $display("FAIL ar_cycle0: got valid=%b addr=%h idle=%b want 1 40 1",
                         mst_bus.ar_valid, mst_bus.ar_addr, idle);
    end
`else
    if ({mst_bus.ar_valid, slv_bus.ar_ready, idle} !== 3'b011) begin
      errors++; $display("FAIL ar_cycle0: got valid/ready/idle=%b want 011",
                         {mst_bus.ar_valid, slv_bus.ar_ready, idle});
    end
`endif
    @(negedge clk);
    slv_bus.ar_valid = 1'b0;
    #1;
    checks++;
`ifdef AXI_CHANNEL_BUFFER_FALLTHROUGH_EN
    if ({mst_bus.ar_valid, idle} !== 2'b01) begin
      errors++; $display("FAIL ar_cycle1: got valid/idle=%b want 01", {mst_bus.ar_valid, idle});
    end
`else
    if ({mst_bus.ar_valid, mst_bus.ar_addr, mst_bus.ar_id, idle} !== {1'b1, 32'h40, 10'd9, 1'b0}) begin
      errors++; $display("FAIL ar_cycle1: got valid=%b addr=%h idle=%b want 1 40 0",
                         mst_bus.ar_valid, mst_bus.ar_addr, idle);
    end
`endif
    @(negedge clk);
    #1;
    checks++;
    if ({mst_bus.ar_valid, idle} !== 2'b01) begin
      errors++; $display("FAIL ar_cycle2: got valid/idle=%b want 01", {mst_bus.ar_valid, idle});
    end
    mst_bus.ar_ready = 1'b0;
  endtask

  // AR stream with mostly-continuous valid and random ready; queue reference model.
  task automatic test_back_to_back();
    localparam int NB = 30;
    logic [AWID+IW-1:0] q[$];
    logic [AWID+IW-1:0] beat, exp;
    int  sent = 0, recv = 0, cyc = 0;
    bit  holding = 1'b0, exp_valid, can_push, bypass;
    beat = '0;
    while (recv < NB && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (!holding && sent < NB && $urandom_range(0, 7) != 0) begin
        beat = {32'($urandom), IW'(sent)};
        holding = 1'b1;
      end
      slv_bus.ar_valid = holding;
      {slv_bus.ar_addr, slv_bus.ar_id} = beat;
      mst_bus.ar_ready = ($urandom_range(0, 3) != 0);
      #1;
      can_push = (q.size() < AR_D);
      bypass = FT && (q.size() == 0) && mst_bus.ar_ready;
      exp_valid = bypass ? holding : (q.size() != 0);
      exp = bypass ? beat : ((q.size() != 0) ? q[0] : '0);
      checks++;
      if ({slv_bus.ar_ready, mst_bus.ar_valid} !== {can_push, exp_valid}) begin
        errors++; $display("FAIL b2b_handshake: got ready/valid=%b want %b (cycle %0d)",
                           {slv_bus.ar_ready, mst_bus.ar_valid}, {can_push, exp_valid}, cyc);
      end
      if (exp_valid && mst_bus.ar_valid === 1'b1) begin
        checks++;
        if ({mst_bus.ar_addr, mst_bus.ar_id} !== exp) begin
          errors++; $display("FAIL b2b_payload: got addr=%h id=%0d want %h",
                             mst_bus.ar_addr, mst_bus.ar_id, exp);
        end
      end
      if (bypass) begin
        if (holding) begin sent++; recv++; holding = 1'b0; end
      end else begin
        if (exp_valid && mst_bus.ar_ready) begin void'(q.pop_front()); recv++; end
        if (holding && can_push) begin q.push_back(beat); sent++; holding = 1'b0; end
      end
    end
    @(negedge clk);
    slv_bus.ar_valid = 1'b0; mst_bus.ar_ready = 1'b0;
    checks++;
    if (recv != NB) begin
      errors++; $display("FAIL b2b_done: got %0d beats want %0d", recv, NB);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_async_reset();
    test_aw_fill();
    test_w_burst();
    test_r_full();
    test_b_passthrough();
    test_ar_latency();
    test_back_to_back();
    @(negedge clk);
    #1;
    checks++;
    if (idle !== 1'b1) begin
      errors++; $display("FAIL final_idle: got %b want 1", idle);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
